// File: rtl/valid_ready_mem.sv
// rtl/valid_ready_mem.sv - single-port RAM slave with valid/ready request handshake
module valid_ready_mem #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_res,
    input  logic                  i_wr_rd,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_valid,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_ready
);

    // Index width covers only the implemented words; out-of-range addresses
    // are filtered before indexing so they never alias onto a real word.
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DEPTH_U = DEPTH;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_ready;
    logic [WIDTH-1:0] r_rdata;

    logic             w_accept;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;

    // A held request is ignored during its own ack cycle, so it runs once.
    assign w_accept   = i_valid && !r_ready;
    assign w_in_range = (32'(i_addr) < DEPTH_U);
    assign w_idx      = i_addr[IDX_W-1:0];

    // Handshake acknowledge and registered read data.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_ready <= 1'b1;
            if (!i_wr_rd) begin
                r_rdata <= w_in_range ? r_mem[w_idx] : '0;
            end
        end else begin
            r_ready <= 1'b0;
        end
    end

    // Storage array; reset clears every word, out-of-range writes are dropped.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept && i_wr_rd && w_in_range) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

    assign o_ready = r_ready;
    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_valid_ready_mem.sv
// tb/tb_valid_ready_mem.sv - self-checking bench for valid_ready_mem
module tb_valid_ready_mem;

    logic        clk = 1'b0;
    logic        res;
    logic        wr_rd, valid;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;

    logic        wr_rd2, valid2;
    logic [7:0]  addr2;
    logic [15:0] wdata2;
    logic [15:0] rdata2;
    logic        ready2;

    int passed = 0;
    int total  = 0;

    // Reference: plain word arrays plus the last value a read returned.
    logic [15:0] model [256];
    logic [15:0] m_rdata;

    always #5 clk = ~clk;

    valid_ready_mem dut (
        .i_clk(clk), .i_res(res), .i_wr_rd(wr_rd), .i_addr(addr),
        .i_wdata(wdata), .i_valid(valid), .o_rdata(rdata), .o_ready(ready)
    );

    valid_ready_mem #(.WIDTH(16), .ADDR_WIDTH(8), .DEPTH(100)) dut2 (
        .i_clk(clk), .i_res(res), .i_wr_rd(wr_rd2), .i_addr(addr2),
        .i_wdata(wdata2), .i_valid(valid2), .o_rdata(rdata2), .o_ready(ready2)
    );

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) model[i] = 16'h0;
        m_rdata = 16'h0;
    endfunction

    function automatic void model_apply(input logic w, input logic [7:0] a, input logic [15:0] d);
        if (w) model[a] = d;
        else   m_rdata = model[a];
    endfunction

    // One isolated transaction on dut: accept edge, then drop valid through the ack edge.
    task automatic txn(input logic w, input logic [7:0] a, input logic [15:0] d,
                       output logic r1, output logic r2, output logic [15:0] rd);
        wr_rd = w; addr = a; wdata = d; valid = 1'b1;
        @(posedge clk); #1;
        r1 = ready; rd = rdata;
        valid = 1'b0; wr_rd = 1'($urandom); addr = 8'($urandom); wdata = 16'($urandom);
        @(posedge clk); #1;
        r2 = ready;
    endtask

    task automatic txn2(input logic w, input logic [7:0] a, input logic [15:0] d,
                        output logic r1, output logic [15:0] rd);
        wr_rd2 = w; addr2 = a; wdata2 = d; valid2 = 1'b1;
        @(posedge clk); #1;
        r1 = ready2; rd = rdata2;
        valid2 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic r1, r2;
        logic [15:0] rd;
        res = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else passed++;
        total++; if (rdata !== 16'h0) $display("FAIL reset_rdata: got %h expected 0000", rdata); else passed++;
        res = 1'b0;
        model_clear();
        foreach (model[i]) model[i] = 16'hFFFF;
        model_clear();
        txn(1'b0, 8'd0, 16'h0, r1, r2, rd);
        total++; if (r1 !== 1'b1 || rd !== 16'h0) $display("FAIL reset_read0: ready %b rdata %h expected 1 0000", r1, rd); else passed++;
        txn(1'b0, 8'd255, 16'h0, r1, r2, rd);
        total++; if (r1 !== 1'b1 || rd !== 16'h0) $display("FAIL reset_read255: ready %b rdata %h expected 1 0000", r1, rd); else passed++;
    endtask

    task automatic test_sweep();
        logic r1, r2;
        logic [15:0] rd;
        for (int i = 0; i < 16; i++) begin
            txn(1'b1, 8'(i), 16'(i * 10), r1, r2, rd);
            model_apply(1'b1, 8'(i), 16'(i * 10));
            total++; if (r1 !== 1'b1 || r2 !== 1'b0) $display("FAIL sweep_wr_pulse[%0d]: ready %b,%b expected 1,0", i, r1, r2); else passed++;
            total++; if (rd !== m_rdata) $display("FAIL sweep_wr_hold[%0d]: rdata %h expected %h", i, rd, m_rdata); else passed++;
        end
        for (int i = 0; i < 16; i++) begin
            txn(1'b0, 8'(i), 16'h0, r1, r2, rd);
            model_apply(1'b0, 8'(i), 16'h0);
            total++; if (r1 !== 1'b1 || r2 !== 1'b0) $display("FAIL sweep_rd_pulse[%0d]: ready %b,%b expected 1,0", i, r1, r2); else passed++;
            total++; if (rd !== m_rdata || rd !== 16'(i * 10)) $display("FAIL sweep_rd[%0d]: rdata %h expected %h", i, rd, 16'(i * 10)); else passed++;
        end
    endtask

    task automatic test_held_valid();
        logic r1, r2;
        logic [15:0] rd;
        logic exp_rdy;
        wr_rd = 1'b1; addr = 8'h20; wdata = 16'hBEEF; valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            exp_rdy = (k % 2 == 0);
            total++; if (ready !== exp_rdy) $display("FAIL held_ready[%0d]: got %b expected %b", k, ready, exp_rdy); else passed++;
            total++; if (rdata !== m_rdata) $display("FAIL held_rdata[%0d]: got %h expected %h", k, rdata, m_rdata); else passed++;
        end
        valid = 1'b0;
        model_apply(1'b1, 8'h20, 16'hBEEF);
        txn(1'b0, 8'h20, 16'h0, r1, r2, rd);
        model_apply(1'b0, 8'h20, 16'h0);
        total++; if (r1 !== 1'b1 || rd !== 16'hBEEF) $display("FAIL held_readback: ready %b rdata %h expected 1 beef", r1, rd); else passed++;
    endtask

    task automatic test_overwrite();
        logic r1, r2;
        logic [15:0] rd;
        txn(1'b1, 8'd5, 16'h1234, r1, r2, rd); model_apply(1'b1, 8'd5, 16'h1234);
        txn(1'b1, 8'd5, 16'h5678, r1, r2, rd); model_apply(1'b1, 8'd5, 16'h5678);
        txn(1'b0, 8'd5, 16'h0, r1, r2, rd);    model_apply(1'b0, 8'd5, 16'h0);
        total++; if (rd !== 16'h5678) $display("FAIL overwrite_read: rdata %h expected 5678", rd); else passed++;
        txn(1'b1, 8'd6, 16'hA5A5, r1, r2, rd); model_apply(1'b1, 8'd6, 16'hA5A5);
        total++; if (r1 !== 1'b1 || rd !== 16'h5678) $display("FAIL overwrite_hold: ready %b rdata %h expected 1 5678", r1, rd); else passed++;
    endtask

    task automatic test_mid_reset();
        logic r1, r2;
        logic [15:0] rd;
        // Reset before the accepting edge: nothing written, no ack.
        txn(1'b1, 8'd3, 16'h1111, r1, r2, rd);
        wr_rd = 1'b1; addr = 8'd3; wdata = 16'h00AA; valid = 1'b1;
        #2 res = 1'b1;
        #1;
        total++; if (ready !== 1'b0 || rdata !== 16'h0) $display("FAIL midrst_async: ready %b rdata %h expected 0 0000", ready, rdata); else passed++;
        #1 res = 1'b0; valid = 1'b0;
        model_clear();
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) $display("FAIL midrst_noack: ready %b expected 0", ready); else passed++;
        txn(1'b0, 8'd3, 16'h0, r1, r2, rd);
        total++; if (r1 !== 1'b1 || rd !== 16'h0) $display("FAIL midrst_read3: ready %b rdata %h expected 1 0000", r1, rd); else passed++;
        // Reset during the ack cycle: ready drops at once and the write is cleared.
        wr_rd = 1'b1; addr = 8'd7; wdata = 16'h0055; valid = 1'b1;
        @(posedge clk); #1;
        total++; if (ready !== 1'b1) $display("FAIL ackrst_ack: ready %b expected 1", ready); else passed++;
        #1 res = 1'b1;
        #1;
        total++; if (ready !== 1'b0) $display("FAIL ackrst_drop: ready %b expected 0", ready); else passed++;
        res = 1'b0; valid = 1'b0;
        model_clear();
        @(posedge clk); #1;
        txn(1'b0, 8'd7, 16'h0, r1, r2, rd);
        total++; if (r1 !== 1'b1 || rd !== 16'h0) $display("FAIL ackrst_read7: ready %b rdata %h expected 1 0000", r1, rd); else passed++;
    endtask

    task automatic test_random();
        logic held = 1'b0;
        logic w;
        logic [7:0] a;
        logic [15:0] d;
        int errs_before;
        errs_before = total - passed;
        for (int n = 0; n < 200; n++) begin
            w = 1'($urandom);
            a = ($urandom % 4 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
            d = 16'($urandom);
            wr_rd = w; addr = a; wdata = d; valid = 1'b1;
            if (held) begin
                @(posedge clk); #1;
                total++; if (ready !== 1'b0 || rdata !== m_rdata) $display("FAIL rand_ackcycle[%0d]: ready %b rdata %h expected 0 %h", n, ready, rdata, m_rdata); else passed++;
            end
            @(posedge clk); #1;
            model_apply(w, a, d);
            total++; if (ready !== 1'b1) $display("FAIL rand_ready[%0d]: got %b expected 1", n, ready); else passed++;
            total++; if (rdata !== m_rdata) $display("FAIL rand_rdata[%0d]: got %h expected %h", n, rdata, m_rdata); else passed++;
            held = 1'b1;
            if ($urandom % 3 == 0) begin
                valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
                total++; if (ready !== 1'b0) $display("FAIL rand_idle[%0d]: ready %b expected 0", n, ready); else passed++;
                held = 1'b0;
            end
        end
        valid = 1'b0;
        @(posedge clk); #1;
        if (total - passed != errs_before) $display("random phase: %0d new errors", total - passed - errs_before);
    endtask

    task automatic test_out_of_range();
        logic r1;
        logic [15:0] rd;
        txn2(1'b1, 8'd50, 16'h4242, r1, rd);
        txn2(1'b1, 8'd99, 16'h9999, r1, rd);
        txn2(1'b1, 8'd150, 16'h7777, r1, rd);
        total++; if (r1 !== 1'b1) $display("FAIL oor_wr_ack: ready %b expected 1", r1); else passed++;
        txn2(1'b1, 8'd100, 16'h6666, r1, rd);
        total++; if (r1 !== 1'b1) $display("FAIL oor_wr100_ack: ready %b expected 1", r1); else passed++;
        txn2(1'b0, 8'd150, 16'h0, r1, rd);
        total++; if (r1 !== 1'b1 || rd !== 16'h0) $display("FAIL oor_rd150: ready %b rdata %h expected 1 0000", r1, rd); else passed++;
        txn2(1'b0, 8'd50, 16'h0, r1, rd);
        total++; if (r1 !== 1'b1 || rd !== 16'h4242) $display("FAIL oor_rd50: ready %b rdata %h expected 1 4242", r1, rd); else passed++;
        txn2(1'b0, 8'd22, 16'h0, r1, rd);
        total++; if (rd !== 16'h0) $display("FAIL oor_alias22: rdata %h expected 0000", rd); else passed++;
        txn2(1'b0, 8'd99, 16'h0, r1, rd);
        total++; if (rd !== 16'h9999) $display("FAIL oor_rd99: rdata %h expected 9999", rd); else passed++;
        txn2(1'b0, 8'd100, 16'h0, r1, rd);
        total++; if (r1 !== 1'b1 || rd !== 16'h0) $display("FAIL oor_rd100: ready %b rdata %h expected 1 0000", r1, rd); else passed++;
        txn2(1'b0, 8'd0, 16'h0, r1, rd);
        total++; if (rd !== 16'h0) $display("FAIL oor_alias0: rdata %h expected 0000", rd); else passed++;
    endtask

    initial begin
        res = 1'b1; valid = 1'b0; wr_rd = 1'b0; addr = 8'h0; wdata = 16'h0;
        valid2 = 1'b0; wr_rd2 = 1'b0; addr2 = 8'h0; wdata2 = 16'h0;
        test_reset();
        test_sweep();
        test_held_valid();
        test_overwrite();
        test_mid_reset();
        test_random();
        test_out_of_range();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
